ahb_apb_bridge: RTL and testbench



---
 rtl/ahb_apb_pkg.sv | 25 ++
 rtl/apb_decoder.sv | 30 +++
 rtl/ahb_apb_bridge.sv | 185 ++++++++++++++++++
 tb/tb_ahb_apb_bridge.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared encodings for the AHB-to-APB bridge.
//   - HTRANS transfer-type encodings
//   - HRESP response encodings
//   - bridge FSM state type
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StLatch  = 3'd1,
      StSetup  = 3'd2,
      StAccess = 3'd3,
      StResp   = 3'd4,
      StErr1   = 3'd5,
      StErr2   = 3'd6
   } bridge_state_t;

endpackage

// File: rtl/apb_decoder.sv
// apb_decoder: combinational peripheral decode for the AHB-to-APB bridge.
// Ports:
//   i_addr     registered transfer address
//   o_sel      one-hot peripheral select (index = i_addr >> SLV_SHIFT)
//   o_in_range 1 when the index addresses an existing peripheral
module apb_decoder #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned NUM_SLV   = 4,
   parameter int unsigned SLV_SHIFT = 12
) (
   input  logic [ADDR_W-1:0]  i_addr,
   output logic [NUM_SLV-1:0] o_sel,
   output logic               o_in_range
);

   logic [ADDR_W-1:0] w_idx;

   assign w_idx      = i_addr >> SLV_SHIFT;
   assign o_in_range = (w_idx < ADDR_W'(NUM_SLV));

   always_comb begin
      o_sel = '0;
      for (int i = 0; i < int'(NUM_SLV); i++) begin
         if (w_idx == ADDR_W'(i)) begin
            o_sel[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_apb_bridge.sv
// ahb_apb_bridge: AHB slave that turns each valid AHB transfer into one APB
// SETUP/ACCESS sequence on one of NUM_SLV peripherals. Single clock domain.
// Optional feature macro: AHB_APB_BRIDGE_ERR_EN
//   defined   - PSLVERR and out-of-range addresses give a two-cycle ERROR
//   undefined - PSLVERR ignored, out-of-range gives OKAY (reads return 0,
//               writes dropped), HRESP tied to OKAY
// Ports:
//   HCLK, HRESETn                      clock, synchronous active-low reset
//   HSEL, HADDR, HWRITE, HTRANS,
//   HWDATA, HREADY                     AHB slave inputs
//   HREADYOUT, HRDATA, HRESP           AHB slave outputs
//   PADDR, PSEL, PENABLE, PWRITE,
//   PWDATA                             APB master outputs
//   PRDATA, PREADY, PSLVERR            APB inputs (muxed externally)
module ahb_apb_bridge
   import ahb_apb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_SLV   = 4,
   parameter int unsigned SLV_SHIFT = 12
) (
   input  logic               HCLK,
   input  logic               HRESETn,
   input  logic               HSEL,
   input  logic [ADDR_W-1:0]  HADDR,
   input  logic               HWRITE,
   input  logic [1:0]         HTRANS,
   input  logic [DATA_W-1:0]  HWDATA,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic [DATA_W-1:0]  HRDATA,
   output logic               HRESP,
   output logic [ADDR_W-1:0]  PADDR,
   output logic [NUM_SLV-1:0] PSEL,
   output logic               PENABLE,
   output logic               PWRITE,
   output logic [DATA_W-1:0]  PWDATA,
   input  logic [DATA_W-1:0]  PRDATA,
   input  logic               PREADY,
   input  logic               PSLVERR
);

   bridge_state_t r_state, w_state_nxt;

   logic [ADDR_W-1:0]  r_addr;
   logic               r_write;
   logic [DATA_W-1:0]  r_pwdata;
   logic [DATA_W-1:0]  r_hrdata;

   logic [NUM_SLV-1:0] w_sel;
   logic               w_in_range;
   logic               w_valid;
   logic               w_take;
   logic               w_rd_done;
   logic               w_hreadyout;
   logic               w_hresp;
   logic               w_psel_en;
   logic               w_penable;
   logic               w_slv_err;

   apb_decoder #(
      .ADDR_W    (ADDR_W),
      .NUM_SLV   (NUM_SLV),
      .SLV_SHIFT (SLV_SHIFT)
   ) u_apb_decoder (
      .i_addr     (r_addr),
      .o_sel      (w_sel),
      .o_in_range (w_in_range)
   );

   // IDLE and BUSY have HTRANS[1]=0, so they never start an APB access.
   assign w_valid = HSEL & HREADY & HTRANS[1];

   // New address phases are only accepted while the bridge drives HREADYOUT=1.
   assign w_take = w_valid &
                   ((r_state == StIdle) | (r_state == StResp) | (r_state == StErr2));

`ifdef AHB_APB_BRIDGE_ERR_EN
   assign w_slv_err = PSLVERR;
`else
   assign w_slv_err = 1'b0;
`endif

   assign w_rd_done = (r_state == StAccess) & PREADY & ~r_write & ~w_slv_err;

   always_comb begin
      w_state_nxt = r_state;
      w_hreadyout = 1'b1;
      w_hresp     = HRESP_OKAY;
      w_psel_en   = 1'b0;
      w_penable   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (w_valid) w_state_nxt = StLatch;
         end
         StLatch: begin
            w_hreadyout = 1'b0;
            if (w_in_range) begin
               w_state_nxt = StSetup;
            end else begin
`ifdef AHB_APB_BRIDGE_ERR_EN
               w_state_nxt = StErr1;
`else
               w_state_nxt = StResp;
`endif
            end
         end
         StSetup: begin
            w_hreadyout = 1'b0;
            w_psel_en   = 1'b1;
            w_state_nxt = StAccess;
         end
         StAccess: begin
            w_hreadyout = 1'b0;
            w_psel_en   = 1'b1;
            w_penable   = 1'b1;
            if (PREADY) w_state_nxt = w_slv_err ? StErr1 : StResp;
         end
         StResp: begin
            w_state_nxt = w_valid ? StLatch : StIdle;
         end
         StErr1: begin
            w_hreadyout = 1'b0;
            w_hresp     = HRESP_ERROR;
            w_state_nxt = StErr2;
         end
         StErr2: begin
            w_hresp     = HRESP_ERROR;
            w_state_nxt = w_valid ? StLatch : StIdle;
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         r_state  <= StIdle;
         r_addr   <= '0;
         r_write  <= 1'b0;
         r_pwdata <= '0;
         r_hrdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_take) begin
            r_addr  <= HADDR;
            r_write <= HWRITE;
         end
         // HWDATA is valid during the data phase, i.e. while in LATCH.
         if ((r_state == StLatch) && r_write && w_in_range) begin
            r_pwdata <= HWDATA;
         end
`ifndef AHB_APB_BRIDGE_ERR_EN
         // Out-of-range reads complete with OKAY and zero data.
         if ((r_state == StLatch) && !r_write && !w_in_range) begin
            r_hrdata <= '0;
         end
`endif
         if (w_rd_done) begin
            r_hrdata <= PRDATA;
         end
      end
   end

   assign HREADYOUT = w_hreadyout;
   assign HRDATA    = r_hrdata;
   assign PADDR     = r_addr;
   assign PSEL      = w_psel_en ? w_sel : '0;
   assign PENABLE   = w_penable;
   assign PWRITE    = r_write;
   assign PWDATA    = r_pwdata;

`ifdef AHB_APB_BRIDGE_ERR_EN
   assign HRESP = w_hresp;
   logic w_unused;
   assign w_unused = HTRANS[0];
`else
   assign HRESP = HRESP_OKAY;
   logic w_unused;
   assign w_unused = HTRANS[0] ^ PSLVERR ^ w_hresp;
`endif

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed self-checking bench for ahb_apb_bridge. HREADY is looped back from
// HREADYOUT, as when the bridge is the only slave on the bus.
module tb_ahb_apb_bridge;

   logic        HCLK;
   logic        HRESETn;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic [31:0] HRDATA;
   logic        HRESP;
   logic [31:0] PADDR;
   logic [3:0]  PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;
   logic        PSLVERR;

   int n_tests = 0;
   int n_fail  = 0;

   ahb_apb_bridge dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HWRITE    (HWRITE),
      .HTRANS    (HTRANS),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRDATA    (HRDATA),
      .HRESP     (HRESP),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   assign HREADY = HREADYOUT;

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one address phase; on return the bridge is in LATCH (T1).
   task automatic start(input logic [31:0] addr, input logic write);
      HSEL   = 1'b1;
      HADDR  = addr;
      HWRITE = write;
      HTRANS = 2'b10;
      tick();
      HTRANS = 2'b00;
      HADDR  = 32'hFFFF_FFFF;
   endtask

   initial begin
      HRESETn = 1'b0;
      HSEL    = 1'b0;
      HADDR   = '0;
      HWRITE  = 1'b0;
      HTRANS  = 2'b00;
      HWDATA  = '0;
      PRDATA  = '0;
      PREADY  = 1'b1;
      PSLVERR = 1'b0;
      tick();
      tick();

      // Reset state
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp",     32'(HRESP),     32'd0);
      chk("rst_hrdata",    HRDATA,         32'd0);
      chk("rst_paddr",     PADDR,          32'd0);
      chk("rst_psel",      32'(PSEL),      32'd0);
      chk("rst_penable",   32'(PENABLE),   32'd0);
      chk("rst_pwrite",    32'(PWRITE),    32'd0);
      chk("rst_pwdata",    PWDATA,         32'd0);
      HRESETn = 1'b1;
      tick();

      // Zero-wait write to peripheral 1
      HWDATA = 32'hA5A5_0001;
      PREADY = 1'b1;
      start(32'h0000_1004, 1'b1);
      chk("wr_t1_hreadyout", 32'(HREADYOUT), 32'd0);
      chk("wr_t1_psel",      32'(PSEL),      32'd0);
      tick();
      chk("wr_t2_psel",    32'(PSEL),    32'b0010);
      chk("wr_t2_paddr",   PADDR,        32'h0000_1004);
      chk("wr_t2_pwrite",  32'(PWRITE),  32'd1);
      chk("wr_t2_pwdata",  PWDATA,       32'hA5A5_0001);
      chk("wr_t2_penable", 32'(PENABLE), 32'd0);
      tick();
      chk("wr_t3_penable", 32'(PENABLE), 32'd1);
      chk("wr_t3_psel",    32'(PSEL),    32'b0010);
      tick();
      chk("wr_t4_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("wr_t4_hresp",     32'(HRESP),     32'd0);
      chk("wr_t4_psel",      32'(PSEL),      32'd0);
      chk("wr_t4_penable",   32'(PENABLE),   32'd0);
      tick();

      // Read from peripheral 3 with three wait cycles
      PREADY = 1'b0;
      PRDATA = 32'hDEAD_BEEF;
      start(32'h0000_3008, 1'b0);
      tick();
      chk("rd_t2_psel",    32'(PSEL),    32'b1000);
      chk("rd_t2_penable", 32'(PENABLE), 32'd0);
      chk("rd_t2_pwrite",  32'(PWRITE),  32'd0);
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("rd_wait_penable",   32'(PENABLE),   32'd1);
         chk("rd_wait_psel",      32'(PSEL),      32'b1000);
         chk("rd_wait_hreadyout", 32'(HREADYOUT), 32'd0);
         tick();
      end
      chk("rd_t6_penable", 32'(PENABLE), 32'd1);
      PREADY = 1'b1;
      tick();
      chk("rd_t7_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rd_t7_hrdata",    HRDATA,         32'hDEAD_BEEF);
      chk("rd_t7_psel",      32'(PSEL),      32'd0);
      PRDATA = 32'h0BAD_0BAD;
      tick();
      chk("rd_hold_hrdata", HRDATA, 32'hDEAD_BEEF);

      // PSLVERR on a read to peripheral 2
      PRDATA = 32'h1234_5678;
      start(32'h0000_2000, 1'b0);
      tick();
      chk("se_t2_psel", 32'(PSEL), 32'b0100);
      PSLVERR = 1'b1;
      tick();
      tick();
`ifdef AHB_APB_BRIDGE_ERR_EN
      chk("se_err1_hresp",     32'(HRESP),     32'd1);
      chk("se_err1_hreadyout", 32'(HREADYOUT), 32'd0);
      chk("se_err1_psel",      32'(PSEL),      32'd0);
      tick();
      chk("se_err2_hresp",     32'(HRESP),     32'd1);
      chk("se_err2_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("se_err2_psel",      32'(PSEL),      32'd0);
      chk("se_err2_hrdata",    HRDATA,         32'hDEAD_BEEF);
`else
      chk("se_resp_hresp",     32'(HRESP),     32'd0);
      chk("se_resp_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("se_resp_psel",      32'(PSEL),      32'd0);
      chk("se_resp_hrdata",    HRDATA,         32'h1234_5678);
`endif
      PSLVERR = 1'b0;
      tick();

      // Out-of-range read
      start(32'h0000_5000, 1'b0);
      chk("oor_t1_psel", 32'(PSEL), 32'd0);
      tick();
`ifdef AHB_APB_BRIDGE_ERR_EN
      chk("oor_err1_hresp",     32'(HRESP),     32'd1);
      chk("oor_err1_hreadyout", 32'(HREADYOUT), 32'd0);
      chk("oor_err1_psel",      32'(PSEL),      32'd0);
      tick();
      chk("oor_err2_hresp",     32'(HRESP),     32'd1);
      chk("oor_err2_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("oor_err2_psel",      32'(PSEL),      32'd0);
`else
      chk("oor_resp_hresp",     32'(HRESP),     32'd0);
      chk("oor_resp_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("oor_resp_hrdata",    HRDATA,         32'd0);
      chk("oor_resp_psel",      32'(PSEL),      32'd0);
`endif
      tick();
      chk("oor_idle_psel", 32'(PSEL), 32'd0);

      // IDLE / BUSY / unselected transfers are ignored
      HSEL   = 1'b1;
      HADDR  = 32'h0000_1000;
      HTRANS = 2'b00;
      tick();
      chk("stall_idle_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("stall_idle_psel",      32'(PSEL),      32'd0);
      HTRANS = 2'b01;
      tick();
      tick();
      chk("stall_busy_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("stall_busy_psel",      32'(PSEL),      32'd0);
      HSEL   = 1'b0;
      HTRANS = 2'b10;
      tick();
      tick();
      chk("nosel_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("nosel_psel",      32'(PSEL),      32'd0);
      HTRANS = 2'b00;
      tick();

      // Back-to-back: write 0x0000 then read 0x1000 issued during RESP
      PREADY = 1'b1;
      PRDATA = 32'hCAFE_F00D;
      HWDATA = 32'h0000_0011;
      start(32'h0000_0000, 1'b1);
      tick();
      chk("b2b_w_psel", 32'(PSEL), 32'b0001);
      tick();
      tick();
      chk("b2b_resp_hreadyout", 32'(HREADYOUT), 32'd1);
      start(32'h0000_1000, 1'b0);
      chk("b2b_latch_hreadyout", 32'(HREADYOUT), 32'd0);
      chk("b2b_latch_psel",      32'(PSEL),      32'd0);
      tick();
      chk("b2b_r_psel",    32'(PSEL),    32'b0010);
      chk("b2b_r_paddr",   PADDR,        32'h0000_1000);
      chk("b2b_r_pwrite",  32'(PWRITE),  32'd0);
      chk("b2b_r_penable", 32'(PENABLE), 32'd0);
      tick();
      tick();
      chk("b2b_r_hrdata", HRDATA, 32'hCAFE_F00D);
      tick();

      // Reset asserted during ACCESS
      PREADY = 1'b0;
      start(32'h0000_1000, 1'b0);
      tick();
      tick();
      chk("rst_mid_penable_pre", 32'(PENABLE), 32'd1);
      HRESETn = 1'b0;
      tick();
      chk("rst_mid_psel",      32'(PSEL),      32'd0);
      chk("rst_mid_penable",   32'(PENABLE),   32'd0);
      chk("rst_mid_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_mid_hrdata",    HRDATA,         32'd0);
      chk("rst_mid_paddr",     PADDR,          32'd0);
      HRESETn = 1'b1;
      PREADY  = 1'b1;
      tick();
      chk("rst_mid_idle_psel",      32'(PSEL),      32'd0);
      chk("rst_mid_idle_hreadyout", 32'(HREADYOUT), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
